// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (DATA_BITS, parity, stop bits) with a 2-flop input synchroniser and start-glitch rejection.
// Latency: falling start edge to dataValid = ~3 + (CLKS_PER_BIT-1)/2 + CLKS_PER_BIT*(frame bits after start) cycles; no backpressure.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serialStream,
  output logic                 dataValid,
  output logic [DATA_BITS-1:0] Bite,
  output logic                 parityError,
  output logic                 frameError,
  output logic                 active
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_EN        = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam logic             PAR_ODD       = (PARITY_MODE == 1);

  logic [1:0]           sync_q, sync_d;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 fr_err_q, fr_err_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] bite_q, bite_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 active_q, active_d;
  logic                 rx_s;
  logic                 ferr_now;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], serialStream};
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    fr_err_d  = fr_err_q;
    dv_d      = 1'b0;
    bite_d    = bite_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ferr_now  = fr_err_q | ~rx_s;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          idx_d     = '0;
          par_err_d = 1'b0;
          fr_err_d  = 1'b0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in from the top leaves it at bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = PAR_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rx_s ^ PAR_ODD;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          fr_err_d = ferr_now;
          if (idx_q == IDX_STOP_LAST) begin
            idx_d   = '0;
            dv_d    = 1'b1;
            bite_d  = shift_q;
            perr_d  = par_err_q & PAR_EN;
            ferr_d  = ferr_now;
            // A low final stop means break/held-low line: wait for idle before re-arming.
            state_d = rx_s ? IDLE : WAIT_HIGH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      fr_err_q  <= 1'b0;
      dv_q      <= 1'b0;
      bite_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      fr_err_q  <= fr_err_d;
      dv_q      <= dv_d;
      bite_q    <= bite_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  assign dataValid   = dv_q;
  assign Bite        = bite_q;
  assign parityError = perr_q;
  assign frameError  = ferr_q;
  assign active      = active_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Two receivers (8N1 and 7E2) driven by a serial frame generator; a scoreboard checks every dataValid pulse.
module tb_uart_rx_cfg;
  localparam int C = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ser_a, ser_b;
  logic       dv_a, perr_a, ferr_a, act_a;
  logic [7:0] bite_a;
  logic       dv_b, perr_b, ferr_b, act_b;
  logic [6:0] bite_b;

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .serialStream(ser_a), .dataValid(dv_a), .Bite(bite_a),
    .parityError(perr_a), .frameError(ferr_a), .active(act_a));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .serialStream(ser_b), .dataValid(dv_b), .Bite(bite_b),
    .parityError(perr_b), .frameError(ferr_b), .active(act_b));

  typedef struct {
    int unsigned data;
    bit          perr;
    bit          ferr;
  } exp_t;

  exp_t q_a[$], q_b[$];
  exp_t ea, eb;
  int   t_a[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      t_a.push_back(cyc);
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_pulse: got dataValid=1 expected no pending frame (Bite=0x%0h)", bite_a);
      end else begin
        ea = q_a.pop_front();
        chk("a_bite", 32'(bite_a), ea.data);
        chk("a_perr", 32'(perr_a), 32'(ea.perr));
        chk("a_ferr", 32'(ferr_a), 32'(ea.ferr));
      end
    end
  end

  always @(negedge clk) begin
    if (dv_b === 1'b1) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_pulse: got dataValid=1 expected no pending frame (Bite=0x%0h)", bite_b);
      end else begin
        eb = q_b.pop_front();
        chk("b_bite", 32'(bite_b), eb.data);
        chk("b_perr", 32'(perr_b), 32'(eb.perr));
        chk("b_ferr", 32'(ferr_b), 32'(eb.ferr));
      end
    end
  end

  task automatic set_line(input int which, input logic v);
    if (which == 0) ser_a = v;
    else            ser_b = v;
  endtask

  // Builds the bit sequence from the frame format and queues the word/flags the receiver must report.
  task automatic send_frame(input int which, input int unsigned data, input bit bad_par,
                            input int stop_low_mask, input int gap_bits);
    int          nb, pm, sb;
    int unsigned mask;
    bit          bits[$];
    bit          pb, par_en, ferr, sbit;
    exp_t        e;
    if (which == 0) begin nb = 8; pm = 0; sb = 1; end
    else            begin nb = 7; pm = 2; sb = 2; end
    mask   = (32'd1 << nb) - 32'd1;
    par_en = (pm == 1) || (pm == 2);
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(bit'((data >> i) & 1));
    if (par_en) begin
      pb = ^(data & mask);
      if (pm == 1) pb = ~pb;
      if (bad_par) pb = ~pb;
      bits.push_back(pb);
    end
    ferr = 1'b0;
    for (int s = 0; s < sb; s++) begin
      sbit = !((stop_low_mask >> s) & 1);
      if (!sbit) ferr = 1'b1;
      bits.push_back(sbit);
    end
    e.data = data & mask;
    e.perr = par_en && bad_par;
    e.ferr = ferr;
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
    foreach (bits[i]) begin
      set_line(which, bits[i]);
      repeat (C) @(negedge clk);
    end
    for (int g = 0; g < gap_bits; g++) begin
      set_line(which, 1'b1);
      repeat (C) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, lat, exp_lat, which, mask, gap;
    int unsigned data;
    bit bp;

    rst = 1'b1; ser_a = 1'b1; ser_b = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_dv",   32'(dv_a),   32'd0);
    chk("rst_a_bite", 32'(bite_a), 32'd0);
    chk("rst_a_perr", 32'(perr_a), 32'd0);
    chk("rst_a_ferr", 32'(ferr_a), 32'd0);
    chk("rst_a_act",  32'(act_a),  32'd0);
    chk("rst_b_bite", 32'(bite_b), 32'd0);
    chk("rst_b_act",  32'(act_b),  32'd0);

    // 8N1 word and start-edge-to-pulse latency
    t_a.delete();
    c0 = cyc;
    send_frame(0, 32'h3F, 1'b0, 0, 2);
    chk("t1_pulses", 32'(t_a.size()), 32'd1);
    if (t_a.size() > 0) begin
      lat     = t_a[0] - c0;
      exp_lat = 2 + (C - 1) / 2 + 1 + C * (8 + 0 + 1) + 1;
      total++;
      if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
        bad++;
        $display("FAIL t1_latency: got %0d cycles expected %0d +-1", lat, exp_lat);
      end
    end
    chk("t1_active_idle", 32'(act_a), 32'd0);

    // 7E2: good then corrupted parity
    send_frame(1, 32'h55, 1'b0, 0, 1);
    send_frame(1, 32'h55, 1'b1, 0, 2);

    // low stop bit, line held low, then recovery
    send_frame(0, 32'hA5, 1'b0, 1, 0);
    repeat (40 * C) @(negedge clk);
    chk("t3_wait_high_active", 32'(act_a), 32'd1);
    ser_a = 1'b1;
    repeat (2 * C) @(negedge clk);
    send_frame(0, 32'h12, 1'b0, 0, 1);

    // start glitch shorter than half a bit
    ser_a = 1'b0;
    repeat (3) @(negedge clk);
    ser_a = 1'b1;
    for (int k = 0; k < 12 && act_a !== 1'b0; k++) @(negedge clk);
    chk("t4_glitch_active", 32'(act_a), 32'd0);
    repeat (2 * C) @(negedge clk);

    // reset in the middle of data bit 4
    ser_a = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ser_a = (32'h5A >> i) & 1;
      repeat (C) @(negedge clk);
    end
    ser_a = (32'h5A >> 4) & 1;
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    ser_a = 1'b1;
    chk("t5_dv",   32'(dv_a),   32'd0);
    chk("t5_bite", 32'(bite_a), 32'd0);
    chk("t5_perr", 32'(perr_a), 32'd0);
    chk("t5_ferr", 32'(ferr_a), 32'd0);
    chk("t5_act",  32'(act_a),  32'd0);
    chk("t5_b_bite", 32'(bite_b), 32'd0);
    repeat (12 * C) @(negedge clk);
    send_frame(0, 32'hC3, 1'b0, 0, 1);

    // back-to-back frames, zero idle gap
    t_a.delete();
    send_frame(0, 32'h00, 1'b0, 0, 0);
    send_frame(0, 32'hFF, 1'b0, 0, 0);
    send_frame(0, 32'h81, 1'b0, 0, 2);
    chk("t6_pulses", 32'(t_a.size()), 32'd3);
    if (t_a.size() == 3) begin
      chk("t6_gap1", 32'(t_a[1] - t_a[0]), 32'(10 * C));
      chk("t6_gap2", 32'(t_a[2] - t_a[1]), 32'(10 * C));
    end

    // randomized frames on both channels
    for (int n = 0; n < 24; n++) begin
      which = $urandom_range(0, 1);
      data  = $urandom;
      bp    = (which == 1) && ($urandom_range(0, 3) == 0);
      mask  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (which == 1) ? 3 : 1) : 0;
      gap   = (mask != 0) ? $urandom_range(1, 3) : $urandom_range(0, 2);
      send_frame(which, data, bp, mask, gap);
    end

    ser_a = 1'b1; ser_b = 1'b1;
    repeat (4 * C) @(negedge clk);
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
